bullet_hit_scanner: RTL and testbench

- Downstream consumer of the bullet store. Once per frame it walks the store's second read port (index2 → position2/size2/color2/isRender2) and tests each live bullet against the player hitbox.
- Returns a timed isCollide pulse so the store can de-render the bullet it just hit.
- Owns player HP, the invulnerability window and the death flag. The HUD and game-state logic read these.

---
 rtl/bullet_hit_scanner.sv | 143 ++++++++++++++
 tb/tb_bullet_hit_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_hit_scanner.sv
// Per-frame scan of the bullet store against the player hitbox.
// Owns player HP, invulnerability window and the death flag.
module bullet_hit_scanner #(
  parameter int NUM_BULLETS   = 3,
  parameter int IDX_W         = 3,
  parameter int HP_MAX        = 20,
  parameter int DAMAGE        = 4,
  parameter int HEAL          = 2,
  parameter int INVULN_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             isRun,
  input  logic             frameTick,
  input  logic [15:0]      playerPos,
  input  logic [15:0]      playerSize,
  input  logic             playerMoving,
  output logic [IDX_W-1:0] index2,
  input  logic [15:0]      position2,
  input  logic [15:0]      size2,
  input  logic [1:0]       color2,
  input  logic             isRender2,
  output logic             isCollide,
  output logic [7:0]       hp,
  output logic             isDead,
  output logic             isInvuln,
  output logic             hitPulse
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH
  } state_t;

  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BULLETS - 1);
  localparam logic [7:0] DMG = 8'(DAMAGE);
  localparam logic [7:0] HPM = 8'(HP_MAX);
  localparam logic [IW-1:0] INV_LD = IW'(INVULN_FRAMES);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_collide;
  logic             r_pulse;
  logic [7:0]       r_hp;
  logic [IW-1:0]    r_inv;
  logic             r_dead;

  logic [8:0] w_px, w_py, w_pw, w_ph;
  logic [8:0] w_bx, w_by, w_bw, w_bh;
  logic       w_ovl;
  logic       w_cand;
  logic       w_inv0;
  logic       w_dmg;
  logic       w_heal;
  logic [8:0] w_hp_sum;
  logic [7:0] w_hp_dmg;
  logic [7:0] w_hp_heal;
  logic [7:0] w_hp_next;

  assign w_px = {1'b0, playerPos[15:8]};
  assign w_py = {1'b0, playerPos[7:0]};
  assign w_pw = {1'b0, playerSize[15:8]};
  assign w_ph = {1'b0, playerSize[7:0]};
  assign w_bx = {1'b0, position2[15:8]};
  assign w_by = {1'b0, position2[7:0]};
  assign w_bw = {1'b0, size2[15:8]};
  assign w_bh = {1'b0, size2[7:0]};

  // 9-bit sums so boxes near the 255 edge do not wrap into false hits
  assign w_ovl = (w_bw != 9'd0) && (w_bh != 9'd0)
              && (w_bx < w_px + w_pw)
              && (w_px < w_bx + w_bw)
              && (w_by < w_py + w_ph)
              && (w_py < w_by + w_bh);

  assign w_cand = (r_state == SCAN) && isRender2 && w_ovl;
  assign w_inv0 = (r_inv == '0);
  assign w_dmg  = w_cand && w_inv0
               && ((color2 == 2'b00)
               || ((color2 == 2'b10) && playerMoving));
  assign w_heal = w_cand && (color2 == 2'b01);

  assign w_hp_dmg  = (r_hp > DMG) ? (r_hp - DMG) : 8'd0;
  assign w_hp_sum  = {1'b0, r_hp} + 9'(HEAL);
  assign w_hp_heal = (w_hp_sum > {1'b0, HPM}) ? HPM : w_hp_sum[7:0];
  assign w_hp_next = w_dmg  ? w_hp_dmg
                   : w_heal ? w_hp_heal
                   : r_hp;

  always_ff @(posedge clk) begin
    if (reset || !isRun) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_collide <= 1'b0;
      r_pulse   <= 1'b0;
      r_hp      <= HPM;
      r_inv     <= '0;
      r_dead    <= 1'b0;
    end else begin
      r_collide <= w_dmg || w_heal;
      r_pulse   <= w_dmg;
      r_hp      <= w_hp_next;
      r_dead    <= (w_hp_next == 8'd0);
      if (w_dmg)
        r_inv <= INV_LD;
      else if (frameTick && !w_inv0)
        r_inv <= r_inv - IW'(1);
      unique case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (frameTick && !r_dead)
            r_state <= SCAN;
        end
        SCAN: begin
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_state <= FLUSH;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        FLUSH: begin
          r_idx   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_idx   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign index2    = r_idx;
  assign isCollide = r_collide;
  assign hitPulse  = r_pulse;
  assign hp        = r_hp;
  assign isDead    = r_dead;
  assign isInvuln  = (r_inv != '0);

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Scoreboard bench for bullet_hit_scanner with a small bullet-store model.
// Stimulus pushes expected collisions; a negedge monitor pops and compares.
module tb_bullet_hit_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        isRun;
  logic        frameTick;
  logic [15:0] playerPos;
  logic [15:0] playerSize;
  logic        playerMoving;
  logic [2:0]  index2;
  logic [15:0] position2;
  logic [15:0] size2;
  logic [1:0]  color2;
  logic        isRender2;
  logic        isCollide;
  logic [7:0]  hp;
  logic        isDead;
  logic        isInvuln;
  logic        hitPulse;

  bullet_hit_scanner dut (
    .clk(clk),
    .reset(reset),
    .isRun(isRun),
    .frameTick(frameTick),
    .playerPos(playerPos),
    .playerSize(playerSize),
    .playerMoving(playerMoving),
    .index2(index2),
    .position2(position2),
    .size2(size2),
    .color2(color2),
    .isRender2(isRender2),
    .isCollide(isCollide),
    .hp(hp),
    .isDead(isDead),
    .isInvuln(isInvuln),
    .hitPulse(hitPulse)
  );

  always #5 clk = ~clk;

  logic [15:0] b_pos  [8];
  logic [15:0] b_size [8];
  logic [1:0]  b_col  [8];
  logic        b_live [8];

  always_comb begin
    position2 = b_pos[index2];
    size2     = b_size[index2];
    color2    = b_col[index2];
    isRender2 = b_live[index2];
  end

  typedef struct {
    logic [2:0] idx;
    logic [7:0] hp;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] prev_idx = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (isCollide) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_collide_idx", int'(prev_idx), -1);
      end else begin
        e = exp_q.pop_front();
        chk("collide_idx", int'(prev_idx), int'(e.idx));
        chk("collide_hp", int'(hp), int'(e.hp));
        chk("collide_pulse", int'(hitPulse), int'(e.pulse));
      end
    end else if (hitPulse) begin
      chk("pulse_without_collide", 1, 0);
    end
    prev_idx = index2;
  end

  task automatic push(input int idx, input int h, input int p);
    exp_t e;
    e.idx   = 3'(idx);
    e.hp    = 8'(h);
    e.pulse = 1'(p);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    for (int i = 0; i < 8; i++) begin
      b_pos[i]  = 16'h0;
      b_size[i] = 16'h0;
      b_col[i]  = 2'b00;
      b_live[i] = 1'b0;
    end
  endtask

  task automatic setb(input int i, input int x, input int y,
                      input int c);
    b_pos[i]  = {8'(x), 8'(y)};
    b_size[i] = {8'd8, 8'd8};
    b_col[i]  = 2'(c);
    b_live[i] = 1'b1;
  endtask

  task automatic tick();
    frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
  endtask

  task automatic frame();
    tick();
    cyc(6);
  endtask

  task automatic restart();
    isRun = 1'b0;
    cyc(1);
    isRun = 1'b1;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1;
    isRun = 1'b1;
    frameTick = 1'b0;
    playerPos = {8'd100, 8'd100};
    playerSize = {8'd16, 8'd16};
    playerMoving = 1'b0;
    clr();
    cyc(3);
    chk("reset_hp", int'(hp), 20);
    chk("reset_dead", int'(isDead), 0);
    chk("reset_index", int'(index2), 0);
    chk("reset_collide", int'(isCollide), 0);
    chk("reset_invuln", int'(isInvuln), 0);
    reset = 1'b0;
    cyc(1);

    // basic white hit with index sequence
    setb(0, 108, 110, 0);
    push(0, 16, 1);
    tick();
    chk("seq0", int'(index2), 0);
    cyc(1);
    chk("seq1", int'(index2), 1);
    cyc(1);
    chk("seq2", int'(index2), 2);
    cyc(1);
    chk("seq3", int'(index2), 0);
    cyc(4);
    chk("t1_hp", int'(hp), 16);
    chk("t1_invuln", int'(isInvuln), 1);
    restart();

    // touching edge and unused colour
    clr();
    setb(0, 116, 100, 0);
    setb(1, 108, 110, 3);
    frame();
    chk("edge_hp", int'(hp), 20);

    // blue needs movement
    clr();
    setb(0, 108, 110, 2);
    frame();
    chk("blue_still_hp", int'(hp), 20);
    playerMoving = 1'b1;
    push(0, 16, 1);
    frame();
    chk("blue_move_hp", int'(hp), 16);
    playerMoving = 1'b0;
    restart();

    // two whites: second masked by invuln until it expires
    clr();
    setb(0, 108, 110, 0);
    setb(2, 104, 104, 0);
    push(0, 16, 1);
    frame();
    chk("two_hp", int'(hp), 16);
    b_live[0] = 1'b0;
    push(2, 12, 1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 28) chk("inv_still", int'(isInvuln), 1);
      if (i == 29) chk("inv_clear", int'(isInvuln), 0);
      cyc(5);
    end
    chk("second_hp", int'(hp), 12);
    restart();

    // green heals, capped, consumed at full HP
    clr();
    setb(0, 108, 110, 0);
    setb(1, 100, 100, 1);
    push(0, 16, 1);
    push(1, 18, 0);
    frame();
    b_live[0] = 1'b0;
    push(1, 20, 0);
    frame();
    chk("heal_hp", int'(hp), 20);
    push(1, 20, 0);
    frame();
    chk("heal_full_hp", int'(hp), 20);
    restart();

    // five spaced damaging hits kill the player
    clr();
    setb(0, 108, 110, 0);
    push(0, 16, 1);
    push(0, 12, 1);
    push(0, 8, 1);
    push(0, 4, 1);
    push(0, 0, 1);
    for (int i = 0; i < 121; i++) begin
      tick();
      cyc(5);
    end
    chk("dead_hp", int'(hp), 0);
    chk("dead_flag", int'(isDead), 1);
    tick();
    cyc(1);
    chk("dead_no_scan", int'(index2), 0);
    cyc(4);
    chk("dead_hp_hold", int'(hp), 0);
    isRun = 1'b0;
    cyc(1);
    chk("revive_hp", int'(hp), 20);
    chk("revive_dead", int'(isDead), 0);
    isRun = 1'b1;
    cyc(1);

    // abort mid-scan
    clr();
    setb(2, 108, 110, 0);
    tick();
    cyc(1);
    chk("abort_pre_idx", int'(index2), 1);
    isRun = 1'b0;
    cyc(1);
    chk("abort_idx", int'(index2), 0);
    chk("abort_collide", int'(isCollide), 0);
    chk("abort_hp", int'(hp), 20);
    isRun = 1'b1;
    cyc(6);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
